// File: rtl/camera_qsys_pll_seq_pkg.sv
// Shared definitions for the camera PLL reset sequencer: sequencer states,
// default timing constants and a small constant-sizing helper.
package camera_qsys_pll_seq_pkg;

  localparam int DEF_HOLD_CYCLES         = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_STAGGER_CYCLES      = 8;
  localparam int DEF_NUM_DOMAINS         = 5;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_SYNC_STAGES         = 2;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } seq_state_e;

  // Larger of two integers, used to size shared counters at elaboration.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/camera_qsys_bit_sync.sv
// Multi-flop synchroniser bringing a single asynchronous level into the
// local clock domain. Output lags the input by STAGES clock cycles.
module camera_qsys_bit_sync
  import camera_qsys_pll_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  // Shift the asynchronous input through the flop chain, oldest at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= STAGES'({sync_p, d});
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/camera_qsys_pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock (with a
// retry/timeout budget), then releases the per-domain resets one at a time.
// Loss of lock after release restarts the sequence; exhausting the retry
// budget parks the block in a sticky FAIL state until rst or a soft reset.
module camera_qsys_pll_reset_seq
  import camera_qsys_pll_seq_pkg::*;
#(
  parameter int HOLD_CYCLES         = DEF_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
  parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   soft_reset_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fail,
  output logic [1:0]             retry_count,
  output logic [7:0]             lock_loss_count
);

  // The phase counter times the hold pulse, the stable-lock window and the
  // staggered release. The timeout keeps running through STABLE while the
  // stable window is being counted, so it needs its own counter.
  localparam int PHASE_MAX = max_of(max_of(HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                                    max_of(LOCK_STABLE_CYCLES,
                                           STAGGER_CYCLES * NUM_DOMAINS));
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TMO_W     = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] STABLE_LAST = PHASE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] RELEASE_END = PHASE_W'(STAGGER_CYCLES * NUM_DOMAINS);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

  // Saturating increment for the lock-loss statistic.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  seq_state_e             state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [1:0]             retry_d, retry_inc;
  logic [7:0]             llc_d;
  logic                   pll_rst_d, ready_d, fail_d;
  logic [NUM_DOMAINS-1:0] domain_rst_d;
  logic                   locked_s;

  camera_qsys_bit_sync #(
    .STAGES (DEF_SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    tmo_d        = tmo_q;
    retry_d      = retry_count;
    retry_inc    = retry_count + 2'd1;
    llc_d        = lock_loss_count;
    pll_rst_d    = 1'b1;
    ready_d      = 1'b0;
    fail_d       = 1'b0;
    domain_rst_d = '1;

    if (soft_reset_req) begin
      // A restart request wins over everything, including a coincident
      // lock loss, which is then not counted.
      state_d = ST_PLL_RST;
      phase_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (phase_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            phase_d = '0;
            tmo_d   = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end

        ST_WAIT_LOCK, ST_STABLE: begin
          if (tmo_q == TMO_LAST) begin
            retry_d = retry_inc;
            state_d = (int'(retry_inc) == MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
            phase_d = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (state_q == ST_WAIT_LOCK) begin
              if (locked_s) begin
                state_d = ST_STABLE;
                phase_d = '0;
              end
            end else if (!locked_s) begin
              // Glitch: go back and wait, timeout keeps counting.
              state_d = ST_WAIT_LOCK;
            end else if (phase_q == STABLE_LAST) begin
              state_d = ST_RELEASE;
              phase_d = '0;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end

        ST_RELEASE: begin
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            phase_d = '0;
            llc_d   = sat_inc8(lock_loss_count);
          end else if (phase_q == RELEASE_END) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end

        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_PLL_RST;
            phase_d = '0;
            llc_d   = sat_inc8(lock_loss_count);
          end
        end

        ST_FAIL: begin
          state_d = ST_FAIL;
        end

        default: begin
          state_d = ST_PLL_RST;
          phase_d = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so that they register in
    // step with the state itself.
    pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
    if (state_d == ST_RUN) begin
      domain_rst_d = '0;
    end else if (state_d == ST_RELEASE) begin
      // Bit i drops once STAGGER*(i+1) cycles have elapsed in RELEASE.
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        domain_rst_d[i] = (phase_d < PHASE_W'(STAGGER_CYCLES * (i + 1)));
      end
    end
  end

  // State, counters and all outputs registered on refclk.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q         <= ST_PLL_RST;
      phase_q         <= '0;
      tmo_q           <= '0;
      pll_rst         <= 1'b1;
      domain_rst      <= '1;
      ready           <= 1'b0;
      fail            <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      tmo_q           <= tmo_d;
      pll_rst         <= pll_rst_d;
      domain_rst      <= domain_rst_d;
      ready           <= ready_d;
      fail            <= fail_d;
      retry_count     <= retry_d;
      lock_loss_count <= llc_d;
    end
  end

endmodule

// File: tb/tb_camera_qsys_pll_reset_seq.sv
// Scoreboard bench for camera_qsys_pll_reset_seq: each stimulus step queues
// the output values it should produce at given cycle numbers; a negedge
// monitor retires those entries when their cycle arrives.
module tb_camera_qsys_pll_reset_seq;

  localparam int HOLD     = 4;
  localparam int STABLE   = 8;
  localparam int TIMEOUT  = 32;
  localparam int STAGGER  = 2;
  localparam int NDOM     = 5;
  localparam int MAXR     = 3;
  // Lock drive -> RELEASE entry: 2 sync flops, 1 WAIT_LOCK->STABLE step,
  // then STABLE locked cycles.
  localparam int LOCK_LAT = 2 + 1 + STABLE;
  localparam int ALL_RST  = (1 << NDOM) - 1;
  localparam int REL_LEN  = STAGGER * NDOM;

  logic            refclk = 1'b0;
  logic            rst;
  logic            pll_locked;
  logic            soft_reset_req;
  logic            pll_rst;
  logic [NDOM-1:0] domain_rst;
  logic            ready;
  logic            fail;
  logic [1:0]      retry_count;
  logic [7:0]      lock_loss_count;

  typedef enum int {O_PLLRST, O_DOM, O_READY, O_FAIL, O_RETRY, O_LLC} obs_e;
  typedef struct packed {
    int   cyc;
    obs_e sel;
    int   val;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  camera_qsys_pll_reset_seq #(
    .HOLD_CYCLES         (HOLD),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .STAGGER_CYCLES      (STAGGER),
    .NUM_DOMAINS         (NDOM),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .soft_reset_req  (soft_reset_req),
    .pll_rst         (pll_rst),
    .domain_rst      (domain_rst),
    .ready           (ready),
    .fail            (fail),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int observe(input obs_e s);
    case (s)
      O_PLLRST: return int'(pll_rst);
      O_DOM:    return int'(domain_rst);
      O_READY:  return int'(ready);
      O_FAIL:   return int'(fail);
      O_RETRY:  return int'(retry_count);
      O_LLC:    return int'(lock_loss_count);
      default:  return -1;
    endcase
  endfunction

  task automatic expect_at(input int c, input obs_e s, input int v);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  // Retire every scoreboard entry due this cycle.
  always @(negedge refclk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        check_eq($sformatf("sched_%s", sb[i].sel.name()), cyc, sb[i].cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        check_eq($sformatf("%s@%0d", sb[i].sel.name(), sb[i].cyc),
                 observe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge refclk);
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge refclk);
      n++;
    end
    check_eq("wait_ready", int'(ready), 1);
  endtask

  task automatic wait_pll_rst(input int budget);
    int n;
    n = 0;
    while (pll_rst !== 1'b1 && n < budget) begin
      @(negedge refclk);
      n++;
    end
    check_eq("wait_pll_rst", int'(pll_rst), 1);
  endtask

  // Expected staggered release for RELEASE entered at cycle e.
  task automatic push_release(input int from, input int e);
    int d;
    for (int c = from; c <= e + REL_LEN + 2; c++) begin
      d = 0;
      for (int i = 0; i < NDOM; i++) begin
        if (c < e + STAGGER * (i + 1)) d = d | (1 << i);
      end
      expect_at(c, O_DOM, d);
      expect_at(c, O_READY, (c >= e + REL_LEN + 1) ? 1 : 0);
      expect_at(c, O_PLLRST, 0);
    end
  endtask

  // Lock rises 10 cycles after pll_rst fell at cycle w; run through release.
  task automatic lock_up(input int w);
    int t;
    goto(w + 10);
    pll_locked = 1'b1;
    t = cyc;
    push_release(t + 1, t + LOCK_LAT);
    expect_at(t + LOCK_LAT + REL_LEN + 2, O_RETRY, 0);
    goto(t + LOCK_LAT + REL_LEN + 2);
  endtask

  initial begin
    int t, w, x, y, z, q;
    rst            = 1'b1;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;

    // Reset state
    goto(3);
    expect_at(4, O_PLLRST, 1);
    expect_at(4, O_DOM, ALL_RST);
    expect_at(4, O_READY, 0);
    expect_at(4, O_FAIL, 0);
    expect_at(4, O_RETRY, 0);
    expect_at(4, O_LLC, 0);
    goto(4);
    rst = 1'b0;
    t = cyc;
    expect_at(t + 1, O_PLLRST, 1);
    expect_at(t + HOLD - 1, O_PLLRST, 1);
    expect_at(t + HOLD, O_PLLRST, 0);
    expect_at(t + HOLD, O_DOM, ALL_RST);

    // Nominal bring-up
    lock_up(t + HOLD);

    // Lock loss in RUN
    x = cyc;
    pll_locked = 1'b0;
    expect_at(x + 2, O_DOM, 0);
    expect_at(x + 2, O_READY, 1);
    expect_at(x + 2, O_LLC, 0);
    expect_at(x + 3, O_DOM, ALL_RST);
    expect_at(x + 3, O_READY, 0);
    expect_at(x + 3, O_LLC, 1);
    expect_at(x + 3, O_PLLRST, 1);
    expect_at(x + 2 + HOLD, O_PLLRST, 1);
    expect_at(x + 3 + HOLD, O_PLLRST, 0);

    // Restart with a 3-cycle lock glitch inside STABLE
    w = x + 3 + HOLD;
    goto(w + 3);
    pll_locked = 1'b1;
    for (int c = w + 4; c <= w + 11; c++) expect_at(c, O_DOM, ALL_RST);
    goto(w + 8);
    pll_locked = 1'b0;
    goto(w + 11);
    pll_locked = 1'b1;
    t = cyc;
    push_release(t + 1, t + LOCK_LAT);
    goto(t + LOCK_LAT + REL_LEN + 2);

    // soft_reset_req coincident with lock loss
    y = cyc;
    pll_locked = 1'b0;
    goto(y + 2);
    soft_reset_req = 1'b1;
    expect_at(y + 3, O_PLLRST, 1);
    expect_at(y + 3, O_DOM, ALL_RST);
    expect_at(y + 3, O_READY, 0);
    expect_at(y + 3, O_LLC, 1);
    expect_at(y + 5, O_LLC, 1);
    goto(y + 3);
    soft_reset_req = 1'b0;
    expect_at(y + 2 + HOLD, O_PLLRST, 1);
    expect_at(y + 3 + HOLD, O_PLLRST, 0);

    // Timeouts with lock held low: retries 1, 2, then FAIL
    w = y + 3 + HOLD;
    for (int k = 0; k < MAXR; k++) begin
      expect_at(w + k * (TIMEOUT + HOLD) + TIMEOUT - 1, O_PLLRST, 0);
      expect_at(w + k * (TIMEOUT + HOLD) + TIMEOUT - 1, O_RETRY, k);
      expect_at(w + k * (TIMEOUT + HOLD) + TIMEOUT, O_PLLRST, 1);
      expect_at(w + k * (TIMEOUT + HOLD) + TIMEOUT, O_RETRY, k + 1);
      expect_at(w + k * (TIMEOUT + HOLD) + TIMEOUT, O_FAIL, (k == MAXR - 1) ? 1 : 0);
    end
    z = w + (MAXR - 1) * (TIMEOUT + HOLD) + TIMEOUT;
    expect_at(w + TIMEOUT + HOLD, O_PLLRST, 0);
    expect_at(z, O_DOM, ALL_RST);
    expect_at(z + 26, O_FAIL, 1);
    expect_at(z + 26, O_PLLRST, 1);
    expect_at(z + 26, O_RETRY, MAXR);
    goto(z + 26);

    // soft_reset_req leaves FAIL
    z = cyc;
    soft_reset_req = 1'b1;
    expect_at(z + 1, O_FAIL, 0);
    expect_at(z + 1, O_RETRY, 0);
    expect_at(z + 1, O_PLLRST, 1);
    expect_at(z + 1 + HOLD, O_PLLRST, 0);
    goto(z + 1);
    soft_reset_req = 1'b0;
    goto(z + 1 + HOLD);

    // Saturating lock-loss counter (already 1)
    for (int k = 0; k < 260; k++) begin
      pll_locked = 1'b1;
      wait_ready(200);
      pll_locked = 1'b0;
      wait_pll_rst(10);
      if (k == 252) expect_at(cyc + 1, O_LLC, 254);
    end
    expect_at(cyc + 1, O_LLC, 255);

    // rst in the middle of RUN
    pll_locked = 1'b1;
    wait_ready(200);
    q = cyc;
    rst = 1'b1;
    expect_at(q + 1, O_DOM, ALL_RST);
    expect_at(q + 1, O_READY, 0);
    expect_at(q + 1, O_PLLRST, 1);
    expect_at(q + 1, O_LLC, 0);
    expect_at(q + 1, O_FAIL, 0);
    goto(q + 1);
    rst = 1'b0;
    goto(q + 3);

    check_eq("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/camera_qsys_pll_reset_seq.md
CAMERA_QSYS_PLL_RESET_SEQ -- requirements
Module: camera_qsys_pll_reset_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, pll_rst pulse width in refclk cycles.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive locked cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, maximum cycles from pll_rst deassertion to stable lock.
REQ-004 SHALL have parameter STAGGER_CYCLES, default 8, spacing between successive domain reset releases.
REQ-005 SHALL have parameter NUM_DOMAINS, default 5, number of PLL output clock domains.
REQ-006 SHALL have parameter MAX_RETRIES, default 3, number of timeouts tolerated before FAIL.
REQ-007 SHALL have port refclk, input, 1, the single clock, a free-running 50 MHz reference.
REQ-008 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-009 SHALL have port pll_locked, input, 1, the PLL lock indicator, asynchronous to refclk.
REQ-010 SHALL have port soft_reset_req, input, 1, a single-cycle request to restart the sequence.
REQ-011 SHALL have port pll_rst, output, 1, the PLL reset, active-high.
REQ-012 SHALL have port domain_rst, output, NUM_DOMAINS, per-domain resets, active-high, in release order with bit 0 first.
REQ-013 SHALL have port ready, output, 1, asserted when all domains are released.
REQ-014 SHALL have port fail, output, 1, a sticky lock-failure indication.
REQ-015 SHALL have port retry_count, output, 2, the number of timeouts since the last RUN or soft reset.
REQ-016 SHALL have port lock_loss_count, output, 8, a count of lock losses that saturates at 255.

Function
REQ-017 SHALL synchronise pll_locked through 2 flops; locked_s lags pll_locked by 2 cycles.
REQ-018 SHALL implement the states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN and FAIL.
REQ-019 PLL_RST: pll_rst=1 and domain_rst all 1; after HOLD_CYCLES cycles the block SHALL go to WAIT_LOCK with the timeout counter cleared.
REQ-020 WAIT_LOCK: pll_rst=0; locked_s=1 SHALL move the block to STABLE with the stable counter cleared.
REQ-021 STABLE: locked_s=0 SHALL return the block to WAIT_LOCK without clearing the timeout counter; LOCK_STABLE_CYCLES consecutive locked cycles SHALL move it to RELEASE.
REQ-022 The timeout counter SHALL run in both WAIT_LOCK and STABLE; on reaching LOCK_TIMEOUT_CYCLES, retry_count SHALL increment, then the block SHALL go to FAIL if the new value equals MAX_RETRIES, otherwise to PLL_RST.
REQ-023 RELEASE: domain_rst[i] SHALL fall exactly STAGGER_CYCLES*(i+1) cycles after RELEASE entry.
REQ-024 The block SHALL enter RUN one cycle after domain_rst[NUM_DOMAINS-1] falls; ready SHALL be 1 only in RUN, and retry_count SHALL clear on RUN entry.
REQ-025 Lock loss (locked_s=0 in RELEASE or RUN) SHALL assert all domain_rst and deassert ready on the next cycle, increment lock_loss_count with saturation, and enter PLL_RST.
REQ-026 FAIL: fail=1, pll_rst=1, domain_rst all 1; the block SHALL leave FAIL only on rst or soft_reset_req.
REQ-027 soft_reset_req in any state SHALL cause PLL_RST next cycle, clear retry_count and clear fail.
REQ-028 When soft_reset_req and lock loss occur in the same cycle, soft_reset_req SHALL take priority and lock_loss_count SHALL NOT increment.
REQ-029 A domain_rst bit, once released, SHALL only re-assert via PLL_RST entry, with all bits re-asserting simultaneously.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 rst SHALL be sampled on the refclk rising edge and SHALL take priority over soft_reset_req.
REQ-032 During and after reset: state=PLL_RST, pll_rst=1, domain_rst all 1, ready=0, fail=0, retry_count=0, lock_loss_count=0, all counters 0.
REQ-033 rst asserted mid-RELEASE or mid-RUN SHALL re-assert all domain_rst on the next edge.

Structure
REQ-034 Package camera_qsys_pll_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-035 Sub-module camera_qsys_bit_sync SHALL implement the 2-flop synchroniser, with parameterised depth defaulting to 2.
REQ-036 A single shared phase counter, sized for the largest of TIMEOUT, STABLE and STAGGER*NUM_DOMAINS, SHALL be reused across states.

Verification
Bench parameters: HOLD=4, STABLE=8, TIMEOUT=32, STAGGER=2, NUM_DOMAINS=5, MAX_RETRIES=3.
REQ-037 Nominal: after rst, pll_locked rises 10 cycles after pll_rst falls -> domain_rst bits fall at +2, 4, 6, 8, 10 cycles after RELEASE entry, and ready=1 one cycle after the last bit falls.
REQ-038 Lock glitch: pll_locked drops for 3 cycles during STABLE -> STABLE restarts, with no release until 8 consecutive locked cycles.
REQ-039 Timeout: pll_locked held at 0 -> pll_rst pulses 3 times, retry_count reads 1 then 2, then fail=1 with the block staying in FAIL.
REQ-040 Lock loss in RUN: drop pll_locked -> all domain_rst=1 within 3 cycles of the drop (2 for sync, 1 for register), lock_loss_count increments by 1, and the sequence restarts.
REQ-041 Simultaneous soft_reset_req and lock loss -> PLL_RST is entered and lock_loss_count is unchanged; soft_reset_req in FAIL clears fail and retry_count.
REQ-042 Saturation: 260 lock-loss events -> lock_loss_count holds at 255.
